// File: rtl/max_display.sv
// Multiplexed 4-digit seven-segment display of a captured 16-bit max-finder result.
// Define LEAD_ZERO_BLANK_EN to blank leading zero digits (digit 0 always lit).
module max_display #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [15:0] max,
  input  logic        done,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        dp,
  output logic        shown,
  output logic        o_dbg_state
);

  // Handshake: done is a level-sampled strobe with no ready; every edge with
  // done=1 loads max into the hold register, so a held-high done reloads each cycle.

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } state_t;

  localparam logic [19:0] CNT_MAX = 20'(REFRESH_DIV - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [19:0] r_cnt;
  logic [1:0]  r_idx;
  logic [15:0] r_held;
  logic [6:0]  r_seg;
  logic [3:0]  r_an;
  logic        r_shown;

  logic        w_wrap;
  logic [3:0]  w_nibble;
  logic        w_lead_zero;
  logic        w_blank_digit;
  logic [6:0]  w_hex;
  logic [6:0]  w_seg_nxt;
  logic [3:0]  w_an_nxt;
  logic        w_shown_nxt;

  assign w_wrap = (r_cnt == CNT_MAX);

  // Refresh counter and digit index free-run in both states.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_cnt <= 20'd0;
      r_idx <= 2'd0;
    end else if (w_wrap) begin
      r_cnt <= 20'd0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 20'd1;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_held <= 16'd0;
    end else if (done) begin
      r_held <= max;
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state <= S_BLANK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BLANK: if (done) w_state_nxt = S_SHOW;
      S_SHOW:  w_state_nxt = S_SHOW;
      default: w_state_nxt = S_BLANK;
    endcase
  end

  always_comb begin
    w_nibble    = r_held[3:0];
    w_lead_zero = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nibble    = r_held[3:0];
        w_lead_zero = 1'b0;
      end
      2'd1: begin
        w_nibble    = r_held[7:4];
        w_lead_zero = (r_held[15:4] == 12'd0);
      end
      2'd2: begin
        w_nibble    = r_held[11:8];
        w_lead_zero = (r_held[15:8] == 8'd0);
      end
      default: begin
        w_nibble    = r_held[15:12];
        w_lead_zero = (r_held[15:12] == 4'd0);
      end
    endcase
  end

  always_comb begin
    w_hex = 7'b1111111;
    case (w_nibble)
      4'h0: w_hex = 7'b1000000;
      4'h1: w_hex = 7'b1111001;
      4'h2: w_hex = 7'b0100100;
      4'h3: w_hex = 7'b0110000;
      4'h4: w_hex = 7'b0011001;
      4'h5: w_hex = 7'b0010010;
      4'h6: w_hex = 7'b0000010;
      4'h7: w_hex = 7'b1111000;
      4'h8: w_hex = 7'b0000000;
      4'h9: w_hex = 7'b0010000;
      4'hA: w_hex = 7'b0001000;
      4'hB: w_hex = 7'b0000011;
      4'hC: w_hex = 7'b1000110;
      4'hD: w_hex = 7'b0100001;
      4'hE: w_hex = 7'b0000110;
      default: w_hex = 7'b0001110;
    endcase
  end

  // Output decode works on the current hold/index/state; the result is
  // registered, giving the one-cycle display latency.
  always_comb begin
`ifdef LEAD_ZERO_BLANK_EN
    w_blank_digit = (r_state == S_BLANK) || w_lead_zero;
`else
    w_blank_digit = (r_state == S_BLANK);
`endif
    w_shown_nxt = (r_state == S_SHOW);
    w_seg_nxt   = w_blank_digit ? 7'b1111111 : w_hex;
    w_an_nxt    = 4'b1111;
    if (!w_blank_digit) begin
      case (r_idx)
        2'd0:    w_an_nxt = 4'b1110;
        2'd1:    w_an_nxt = 4'b1101;
        2'd2:    w_an_nxt = 4'b1011;
        default: w_an_nxt = 4'b0111;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_seg   <= 7'b1111111;
      r_an    <= 4'b1111;
      r_shown <= 1'b0;
    end else begin
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      r_shown <= w_shown_nxt;
    end
  end

  assign seg         = r_seg;
  assign an          = r_an;
  assign shown       = r_shown;
  assign dp          = 1'b1;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_max_display.sv
// Randomized scoreboard bench for max_display: one instance with REFRESH_DIV=4,
// one with REFRESH_DIV=1, both against a cycle-count based reference model.
module tb_max_display;

  logic        mclk = 1'b0;
  logic        reset;
  logic        done;
  logic [15:0] max;

  logic [6:0] seg4, seg1;
  logic [3:0] an4, an1;
  logic       dp4, dp1, shown4, shown1, st4, st1;

  int checks = 0;
  int errors = 0;

  localparam logic [12:0] BLANK_V = {1'b0, 1'b1, 4'b1111, 7'b1111111};

  // Expected {shown, dp, an, seg} after each clock edge.
  logic [12:0] exp_q4[$];
  logic [12:0] exp_q1[$];

  // Model: captured value, shown flag and edges counted since reset release.
  logic [15:0] m_held;
  logic        m_show;
  int          m_n;

  always #5 mclk = ~mclk;

  max_display #(.REFRESH_DIV(4)) dut4 (
    .mclk(mclk), .reset(reset), .max(max), .done(done),
    .seg(seg4), .an(an4), .dp(dp4), .shown(shown4), .o_dbg_state(st4)
  );

  max_display #(.REFRESH_DIV(1)) dut1 (
    .mclk(mclk), .reset(reset), .max(max), .done(done),
    .seg(seg1), .an(an1), .dp(dp1), .shown(shown1), .o_dbg_state(st1)
  );

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tab[v];
  endfunction

  function automatic logic [12:0] disp(input logic [15:0] h, input int k, input logic s);
    logic [15:0] upper;
    logic [3:0]  an_v;
    if (!s) return BLANK_V;
    upper = h >> (4 * k);
    if (k > 0) begin
`ifdef LEAD_ZERO_BLANK_EN
      if (upper == 16'd0) return {1'b1, 1'b1, 4'b1111, 7'b1111111};
`endif
    end
    an_v = ~(4'b0001 << k);
    return {1'b1, 1'b1, an_v, hex7(upper[3:0])};
  endfunction

  task automatic cmp(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got shown=%b dp=%b an=%b seg=%b, expected shown=%b dp=%b an=%b seg=%b",
               name, $time, act[12], act[11], act[10:7], act[6:0],
               exp[12], exp[11], exp[10:7], exp[6:0]);
    end
  endtask

  task automatic cmp_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Reference model: pushes the expected display for each edge from the
  // pre-edge captured value, digit k = (edges / REFRESH_DIV) mod 4.
  always @(posedge mclk or posedge reset) begin
    if (reset) begin
      m_held = 16'd0;
      m_show = 1'b0;
      m_n    = 0;
      exp_q4.delete();
      exp_q1.delete();
    end else begin
      exp_q4.push_back(disp(m_held, (m_n / 4) % 4, m_show));
      exp_q1.push_back(disp(m_held, m_n % 4, m_show));
      if (done) begin
        m_held = max;
        m_show = 1'b1;
      end
      m_n++;
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge mclk) begin
    logic [12:0] e4, e1;
    if (reset || exp_q4.size() == 0) e4 = BLANK_V;
    else e4 = exp_q4.pop_front();
    if (reset || exp_q1.size() == 0) e1 = BLANK_V;
    else e1 = exp_q1.pop_front();
    cmp("display_rd4", {shown4, dp4, an4, seg4}, e4);
    cmp("display_rd1", {shown1, dp1, an1, seg1}, e1);
    cmp_bit("state_rd4", st4, reset ? 1'b0 : m_show);
    cmp_bit("state_rd1", st1, reset ? 1'b0 : m_show);
  end

  task automatic cycle(input logic d, input logic [15:0] m);
    @(negedge mclk);
    #1;
    done = d;
    max  = m;
  endtask

  initial begin
    int guard;
    reset = 1'b1;
    done  = 1'b0;
    max   = 16'd0;
    repeat (3) @(negedge mclk);
    #1 reset = 1'b0;

    repeat (40) cycle(1'b0, 16'($urandom));
    cycle(1'b1, 16'h1A3F);
    repeat (40) cycle(1'b0, 16'($urandom));

    // Land the BEEF capture on the edge where the RD=4 index goes 0->1.
    @(negedge mclk);
    #1;
    done  = 1'b0;
    guard = 0;
    while ((m_n % 16) != 3 && guard < 20) begin
      @(negedge mclk);
      #1;
      guard++;
    end
    done = 1'b1;
    max  = 16'hBEEF;
    repeat (40) cycle(1'b0, 16'($urandom));

    repeat (6) cycle(1'b1, 16'($urandom));
    repeat (300) cycle($urandom_range(0, 9) == 0, 16'($urandom));

    // Asynchronous reset in the middle of a digit slot.
    @(negedge mclk);
    #1;
    done  = 1'b0;
    reset = 1'b1;
    #1;
    cmp("async_reset_rd4", {shown4, dp4, an4, seg4}, BLANK_V);
    cmp("async_reset_rd1", {shown1, dp1, an1, seg1}, BLANK_V);
    repeat (3) @(negedge mclk);
    #1 reset = 1'b0;
    repeat (30) cycle(1'b0, 16'($urandom));

    cycle(1'b1, 16'h0007);
    repeat (24) cycle(1'b0, 16'($urandom));
    cycle(1'b1, 16'h8421);
    repeat (24) cycle(1'b0, 16'($urandom));
    repeat (200) cycle($urandom_range(0, 7) == 0, 16'($urandom) & 16'h0FFF);
    cycle(1'b0, 16'd0);
    repeat (2) @(negedge mclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
